// File: rtl/cmc_access_sched.sv
// cmc_access_sched: phase sequencer and requester arbiter for one CMC bank.
// Define CMC_SCHED_FIXED_PRIO_EN for fixed priority; default is round-robin.
module cmc_access_sched #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int PRE_CYC = 2,
  parameter int ACC_CYC = 3
) (
  input  logic                     I_clock,
  input  logic                     I_reset,
  input  logic [NREQ-1:0]          I_req,
  input  logic [NREQ-1:0]          I_we,
  input  logic [NREQ*ADDR_W-1:0]   I_addr,
  input  logic [NREQ*DATA_W-1:0]   I_wdata,
  input  logic [DATA_W-1:0]        I_rdata,
  output logic [NREQ-1:0]          O_gnt,
  output logic [NREQ-1:0]          O_ack,
  output logic [DATA_W-1:0]        O_rdata,
  output logic                     O_precharge,
  output logic                     O_wl_en,
  output logic                     O_we,
  output logic [ADDR_W-1:0]        O_addr,
  output logic [DATA_W-1:0]        O_wdata,
  output logic                     O_busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC  = (PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
  localparam logic [CNT_W-1:0] PRE_INIT = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] ACC_INIT = CNT_W'(ACC_CYC - 1);

  if (PRE_CYC < 1) begin : g_bad_pre
    $error("cmc_access_sched: PRE_CYC must be >= 1");
  end
  if (ACC_CYC < 1) begin : g_bad_acc
    $error("cmc_access_sched: ACC_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACC,
    SENSE,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_lat;
  logic [PTR_W-1:0]  win;
  logic [NREQ-1:0]   win_oh;

`ifdef CMC_SCHED_FIXED_PRIO_EN
  // Lowest requesting index wins; no fairness state.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (I_req[i]) win = PTR_W'(i);
    end
  end
`else
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  idx;

  // Round-robin: first requester at or after ptr, wrapping.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(ptr) + i) % NREQ);
      if (I_req[idx]) win = idx;
    end
  end
`endif

  assign win_oh = NREQ'(1) << win;

  // Access FSM; every array and handshake output is registered here.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we_lat      <= 1'b0;
`ifndef CMC_SCHED_FIXED_PRIO_EN
      ptr         <= '0;
`endif
      O_gnt       <= '0;
      O_ack       <= '0;
      O_rdata     <= '0;
      O_precharge <= 1'b0;
      O_wl_en     <= 1'b0;
      O_we        <= 1'b0;
      O_addr      <= '0;
      O_wdata     <= '0;
      O_busy      <= 1'b0;
    end else begin
      O_ack <= '0;
      unique case (state)
        IDLE: begin
          if (|I_req) begin
            state       <= PRE;
            cnt         <= PRE_INIT;
            we_lat      <= I_we[win];
            O_addr      <= I_addr[int'(win)*ADDR_W +: ADDR_W];
            O_wdata     <= I_wdata[int'(win)*DATA_W +: DATA_W];
            O_gnt       <= win_oh;
            O_precharge <= 1'b1;
            O_busy      <= 1'b1;
`ifndef CMC_SCHED_FIXED_PRIO_EN
            ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`endif
          end
        end
        PRE: begin
          if (cnt == '0) begin
            state       <= ACC;
            cnt         <= ACC_INIT;
            O_precharge <= 1'b0;
            O_wl_en     <= 1'b1;
            O_we        <= we_lat;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACC: begin
          if (cnt == '0) begin
            O_wl_en <= 1'b0;
            O_we    <= 1'b0;
            if (we_lat) begin
              state <= DONE;
              O_ack <= O_gnt;
            end else begin
              state <= SENSE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SENSE: begin
          O_rdata <= I_rdata;
          O_ack   <= O_gnt;
          state   <= DONE;
        end
        DONE: begin
          state   <= IDLE;
          we_lat  <= 1'b0;
          O_gnt   <= '0;
          O_addr  <= '0;
          O_wdata <= '0;
          O_busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmc_access_sched.md
Name: cmc_access_sched

Overview:
- Sequences accesses to one computational-memory-cell bank, which is built from inverter-pair storage cells.
- Arbitrates between NREQ requesters and runs each access through a fixed phase order:
  - write: precharge → wordline drive → done.
  - read: precharge → wordline drive → sense → done.
- Sits between the compute/host requesters and the cell array; it is the only block that drives the array's control lines.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 4, cell-row address width.
- DATA_W, 8, word width.
- PRE_CYC, 2, precharge phase length in cycles (>=1).
- ACC_CYC, 3, wordline phase length in cycles (>=1).

Ports:
- I_clock  in  1  clock; all logic on rising edge.
- I_reset  in  1  synchronous, active-high reset.
- I_req  in  NREQ  level request per requester; held until its ack.
- I_we  in  NREQ  per-requester write flag (1 = write, 0 = read).
- I_addr  in  NREQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- I_wdata  in  NREQ*DATA_W  packed write data; same packing.
- I_rdata  in  DATA_W  array sense-amp output.
- O_gnt  out  NREQ  one-hot grant, held for the whole transaction.
- O_ack  out  NREQ  one-cycle completion pulse to the granted requester.
- O_rdata  out  DATA_W  read result; valid when O_ack pulses on a read.
- O_precharge  out  1  array bitline precharge.
- O_wl_en  out  1  array wordline enable.
- O_we  out  1  array write drive; only ever high while O_wl_en is high.
- O_addr  out  ADDR_W  latched row address.
- O_wdata  out  DATA_W  latched write data.
- O_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, while I_reset=1 at an edge:
  - state=IDLE, phase counter=0, round-robin pointer=0.
  - Every output is 0.
  - Reset overrides mid-transaction: no ack is issued and the array lines drop on that edge.
- States: IDLE, PRE, ACC, SENSE, DONE.
- IDLE:
  - If any I_req bit is set at an edge, arbitrate, then:
    - latch the winner's we/addr/wdata into O_we shadow, O_addr, O_wdata;
    - set O_gnt to the winner's one-hot;
    - go to PRE with O_precharge=1 and counter=PRE_CYC-1.
  - If no request, remain in IDLE with all outputs 0 except O_rdata, which holds.
- PRE:
  - O_precharge=1, O_wl_en=0, O_we=0.
  - Counts down.
  - When the counter reaches 0: go to ACC with counter=ACC_CYC-1, O_precharge=0, O_wl_en=1, O_we=latched we.
- ACC:
  - O_wl_en=1 and O_we=latched we for exactly ACC_CYC cycles.
  - At the end: O_wl_en=0 and O_we=0.
  - Next state is SENSE on a read, DONE on a write.
- SENSE (reads only):
  - Lasts 1 cycle.
  - O_rdata captures I_rdata at the edge leaving SENSE; next state is DONE.
- DONE:
  - Lasts 1 cycle.
  - O_ack[winner]=1 and O_gnt remains asserted.
  - Next state is IDLE; O_gnt and O_ack clear on that edge.
- Latency from the request-sampling edge to the O_ack high cycle:
  - write: PRE_CYC+ACC_CYC+1 cycles.
  - read: PRE_CYC+ACC_CYC+2 cycles.
  - With the defaults: write ack 6 cycles, read ack 7 cycles after sampling.
- Back-to-back: a minimum of one IDLE cycle separates transactions. A request held through DONE is re-arbitrated on the IDLE edge.
- Round-robin arbitration:
  - Search starts at the pointer and wraps NREQ-1→0.
  - On each grant, pointer = winner+1 mod NREQ.
- Request changes during a transaction:
  - Inputs of the active transaction are latched, so requester input changes have no effect.
  - Deasserting I_req mid-transaction does not abort it; the ack still pulses.
- Only the granted requester ever sees O_ack. O_ack and O_gnt are never set for a requester that was not granted.
- O_rdata is unchanged by writes.
- Parameter legality: PRE_CYC or ACC_CYC below 1 is illegal and is flagged by a static assertion in simulation.

Optional Feature:
- Macro: CMC_SCHED_FIXED_PRIO_EN.
- When defined: fixed priority, with the lowest index winning. The pointer register is removed and can starve higher indices.
- When undefined: round-robin as described in Behaviour.

Test Plan:
- Reset mid-ACC:
  - Stimulus: assert I_reset during the 2nd ACC cycle of a write.
  - Required: on that edge all outputs go to 0 and state goes to IDLE; no O_ack. The next request gets the grant with pointer=0 (index 0 wins on a tie).
- Single write:
  - Stimulus: req0 with we=1, addr=4'h5, wdata=8'hA5.
  - Required: O_precharge high 2 cycles, then O_wl_en=O_we=1 for 3 cycles with O_addr=5 and O_wdata=A5. O_ack[0] pulses in cycle 6 after sampling; O_rdata unchanged.
- Single read:
  - Stimulus: req1 with we=0, addr=4'h3, I_rdata=8'h3C.
  - Required: O_we stays 0 throughout, one SENSE cycle, then O_ack[1] in cycle 7 with O_rdata=8'h3C.
- Contention, default build:
  - Stimulus: req0 and req1 held continuously, both writes.
  - Required: grants alternate 1,0,1,0… from pointer=0 after the first grant to 0, i.e. 0,1,0,1. Each transaction is separated by exactly one IDLE cycle.
- Contention, CMC_SCHED_FIXED_PRIO_EN defined:
  - Stimulus: same as the previous case.
  - Required: requester 0 is granted every transaction and requester 1 never.
- Request drop:
  - Stimulus: req0 read started, then I_req[0] deasserted in PRE while I_addr[0] changes to 4'hF.
  - Required: the transaction completes with O_addr at its original value, and O_ack[0] still pulses.
